mpu_collector: RTL and testbench

- Stage directly downstream of the FMA array, alongside the dispatcher. It consumes per-element results (row, col, value) in any order.
- It assembles them into an M x N result matrix and issues a single-cycle write of the complete matrix to the matrix register file at the destination address.
- It reports completion and a sticky error status back to the MPU controller.

---
 rtl/mpu_collector_pkg.sv | 27 ++
 rtl/mpu_collector_if.sv | 33 +++
 rtl/mpu_collector.sv | 112 +++++++++++
 tb/tb_mpu_collector.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mpu_collector_pkg.sv
// mpu_collector_pkg: sizes, element types and write record for the result collector.
package mpu_collector_pkg;
  localparam int M = 3;
  localparam int N = 3;
  localparam int MATRIX_REGISTERS = 8;
  localparam int MATRIX_REG_BITS = $clog2(MATRIX_REGISTERS) - 1;
  localparam int MBITS = $clog2(M + 1) - 1;
  localparam int NBITS = $clog2(N + 1) - 1;
  localparam int FP = 32;
  localparam int NUM_ELEMENTS_MAX = M * N;
  localparam int ELEM_BITS = $clog2(M * N + 1);
  typedef logic [FP-1:0] float_sp;
  typedef logic [MATRIX_REG_BITS:0] addr_t;
  typedef logic [MBITS:0] dim_m_t;
  typedef logic [NBITS:0] dim_n_t;
  typedef float_sp [NUM_ELEMENTS_MAX-1:0] matrix_t;
  typedef enum logic {COLLECTOR_IDLE, COLLECTOR_WRITE} collector_state_e;
  typedef struct packed {
    addr_t   addr;
    dim_m_t  m;
    dim_n_t  n;
    matrix_t matrix;
  } collector_write_s;
  function automatic logic [ELEM_BITS-1:0] elem_idx(dim_m_t r, dim_n_t c);
    return ELEM_BITS'(r) * ELEM_BITS'(N) + ELEM_BITS'(c);
  endfunction
endpackage

// File: rtl/mpu_collector_if.sv
// mpu_collector_if: dispatcher/FMA inputs and register-file/controller outputs of the collector.
interface mpu_collector_if;
  import mpu_collector_pkg::*;
  logic    collect_start_in;
  addr_t   collect_dest_in;
  dim_m_t  collect_m_in;
  dim_n_t  collect_n_in;
  logic    result_valid_in;
  dim_m_t  result_row_in;
  dim_n_t  result_col_in;
  float_sp result_data_in;
  logic    result_error_in;
  logic    collector_ready_out;
  logic    reg_write_en_out;
  addr_t   reg_write_addr_out;
  matrix_t reg_write_matrix_out;
  dim_m_t  reg_write_m_out;
  dim_n_t  reg_write_n_out;
  logic    collect_done_out;
  logic    collect_error_out;
  modport slave (
    input  collect_start_in, collect_dest_in, collect_m_in, collect_n_in,
    input  result_valid_in, result_row_in, result_col_in, result_data_in, result_error_in,
    output collector_ready_out, reg_write_en_out, reg_write_addr_out, reg_write_matrix_out,
    output reg_write_m_out, reg_write_n_out, collect_done_out, collect_error_out
  );
  modport master (
    output collect_start_in, collect_dest_in, collect_m_in, collect_n_in,
    output result_valid_in, result_row_in, result_col_in, result_data_in, result_error_in,
    input  collector_ready_out, reg_write_en_out, reg_write_addr_out, reg_write_matrix_out,
    input  reg_write_m_out, reg_write_n_out, collect_done_out, collect_error_out
  );
endinterface

// File: rtl/mpu_collector.sv
// mpu_collector: gathers out-of-order FMA results into a matrix and writes it to the register file in one cycle.
module mpu_collector
  import mpu_collector_pkg::*;
(
  input logic clk,
  input logic rst,
  mpu_collector_if.slave bus
);
  collector_state_e state_q, state_d;
  logic busy_q, busy_d, ready_q, ready_d, wen_q, wen_d, done_q, done_d;
  logic cerr_q, cerr_d, err_q, err_d, start_ok, hit;
  addr_t dest_q, dest_d;
  dim_m_t m_q, m_d;
  dim_n_t n_q, n_d;
  matrix_t mat_q, mat_d;
  logic [NUM_ELEMENTS_MAX-1:0] pres_q, pres_d;
  logic [ELEM_BITS-1:0] cnt_q, cnt_d, idx;
  collector_write_s wr_q, wr_d;
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    dest_d = dest_q;
    m_d = m_q;
    n_d = n_q;
    mat_d = mat_q;
    pres_d = pres_q;
    cnt_d = cnt_q;
    err_d = err_q;
    wr_d = wr_q;
    wen_d = 1'b0;
    done_d = 1'b0;
    cerr_d = 1'b0;
    idx = elem_idx(bus.result_row_in, bus.result_col_in);
    start_ok = bus.collect_m_in != '0 && bus.collect_m_in <= dim_m_t'(M) &&
               bus.collect_n_in != '0 && bus.collect_n_in <= dim_n_t'(N);
    hit = bus.result_row_in < m_q && bus.result_col_in < n_q && !pres_q[idx];
    if (state_q == COLLECTOR_WRITE) begin
      state_d = COLLECTOR_IDLE;
    end else if (!busy_q && bus.collect_start_in) begin
      done_d = !start_ok;
      cerr_d = !start_ok;
      if (start_ok) begin
        busy_d = 1'b1;
        dest_d = bus.collect_dest_in;
        m_d = bus.collect_m_in;
        n_d = bus.collect_n_in;
        mat_d = '0;
        pres_d = '0;
        cnt_d = '0;
        err_d = 1'b0;
      end
    end else if (busy_q && bus.result_valid_in) begin
      err_d = err_q | (hit ? bus.result_error_in : 1'b1);
      if (hit) begin
        mat_d[idx] = bus.result_data_in;
        pres_d[idx] = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
      // The write record is built from the next-state buffer so the final element lands in it.
      if (cnt_d == ELEM_BITS'(m_q) * ELEM_BITS'(n_q)) begin
        state_d = COLLECTOR_WRITE;
        busy_d = 1'b0;
        wen_d = 1'b1;
        done_d = 1'b1;
        cerr_d = err_d;
        wr_d = '{addr: dest_q, m: m_q, n: n_q, matrix: mat_d};
      end
    end
    ready_d = state_d == COLLECTOR_IDLE && !busy_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECTOR_IDLE;
      busy_q <= 1'b0;
      ready_q <= 1'b1;
      wen_q <= 1'b0;
      done_q <= 1'b0;
      cerr_q <= 1'b0;
      err_q <= 1'b0;
      dest_q <= '0;
      m_q <= '0;
      n_q <= '0;
      mat_q <= '0;
      pres_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
      wen_q <= wen_d;
      done_q <= done_d;
      cerr_q <= cerr_d;
      err_q <= err_d;
      dest_q <= dest_d;
      m_q <= m_d;
      n_q <= n_d;
      mat_q <= mat_d;
      pres_q <= pres_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
    end
  end
  assign bus.collector_ready_out = ready_q;
  assign bus.reg_write_en_out = wen_q;
  assign bus.reg_write_addr_out = wr_q.addr;
  assign bus.reg_write_matrix_out = wr_q.matrix;
  assign bus.reg_write_m_out = wr_q.m;
  assign bus.reg_write_n_out = wr_q.n;
  assign bus.collect_done_out = done_q;
  assign bus.collect_error_out = cerr_q;
endmodule

// File: tb/tb_mpu_collector.sv
// tb_mpu_collector: directed checks of collection order, duplicates, errors, bad starts and reset abort.
module tb_mpu_collector;
  import mpu_collector_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  float_sp f [0:8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                       32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
  matrix_t em;
  mpu_collector_if bus ();
  mpu_collector dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input int d, input int m, input int n);
    bus.collect_start_in = 1'b1;
    bus.collect_dest_in = addr_t'(d);
    bus.collect_m_in = dim_m_t'(m);
    bus.collect_n_in = dim_n_t'(n);
    tick();
    bus.collect_start_in = 1'b0;
  endtask
  task automatic res(input int r, input int c, input float_sp v, input logic e);
    bus.result_valid_in = 1'b1;
    bus.result_row_in = dim_m_t'(r);
    bus.result_col_in = dim_n_t'(c);
    bus.result_data_in = v;
    bus.result_error_in = e;
    tick();
    bus.result_valid_in = 1'b0;
    bus.result_error_in = 1'b0;
  endtask
  task automatic chk_write(input string tag, input int a, input int m, input int n, input logic e);
    chk({tag, ".wen"}, 288'(bus.reg_write_en_out), 288'(1));
    chk({tag, ".addr"}, 288'(bus.reg_write_addr_out), 288'(a));
    chk({tag, ".m"}, 288'(bus.reg_write_m_out), 288'(m));
    chk({tag, ".n"}, 288'(bus.reg_write_n_out), 288'(n));
    chk({tag, ".mat"}, bus.reg_write_matrix_out, em);
    chk({tag, ".done"}, 288'(bus.collect_done_out), 288'(1));
    chk({tag, ".err"}, 288'(bus.collect_error_out), 288'(e));
  endtask
  initial begin
    bus.collect_start_in = 1'b0;
    bus.collect_dest_in = '0;
    bus.collect_m_in = '0;
    bus.collect_n_in = '0;
    bus.result_valid_in = 1'b0;
    bus.result_row_in = '0;
    bus.result_col_in = '0;
    bus.result_data_in = '0;
    bus.result_error_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst.ready", 288'(bus.collector_ready_out), 288'(1));
    chk("rst.wen", 288'(bus.reg_write_en_out), 288'(0));
    chk("rst.done", 288'(bus.collect_done_out), 288'(0));
    chk("rst.mat", bus.reg_write_matrix_out, 288'(0));
    // 3x3 row-major
    start(5, 3, 3);
    chk("a.ready_low", 288'(bus.collector_ready_out), 288'(0));
    for (int i = 0; i < 8; i++) res(i / 3, i % 3, f[i], 1'b0);
    chk("a.wen_early", 288'(bus.reg_write_en_out), 288'(0));
    res(2, 2, f[8], 1'b0);
    for (int i = 0; i < 9; i++) em[i] = f[i];
    chk_write("a", 5, 3, 3, 1'b0);
    tick();
    chk("a.ready_back", 288'(bus.collector_ready_out), 288'(1));
    chk("a.wen_drop", 288'(bus.reg_write_en_out), 288'(0));
    chk("a.done_drop", 288'(bus.collect_done_out), 288'(0));
    chk("a.mat_hold", bus.reg_write_matrix_out, em);
    // 2x2 reverse order
    start(2, 2, 2);
    res(1, 1, f[3], 1'b0);
    res(1, 0, f[2], 1'b0);
    res(0, 1, f[1], 1'b0);
    res(0, 0, f[0], 1'b0);
    em = '0;
    em[0] = f[0];
    em[1] = f[1];
    em[3] = f[2];
    em[4] = f[3];
    chk_write("b", 2, 2, 2, 1'b0);
    tick();
    // duplicate (1,1): first value kept, error set
    start(1, 3, 3);
    res(1, 1, f[4], 1'b0);
    res(1, 1, f[0], 1'b0);
    for (int i = 0; i < 9; i++) if (i != 4) res(i / 3, i % 3, f[i], 1'b0);
    for (int i = 0; i < 9; i++) em[i] = f[i];
    chk_write("c", 1, 3, 3, 1'b1);
    tick();
    // FMA error flag on one element
    start(3, 2, 2);
    res(0, 0, f[0], 1'b0);
    res(0, 1, f[1], 1'b1);
    res(1, 0, f[2], 1'b0);
    chk("d.wen_early", 288'(bus.reg_write_en_out), 288'(0));
    res(1, 1, f[3], 1'b0);
    em = '0;
    em[0] = f[0];
    em[1] = f[1];
    em[3] = f[2];
    em[4] = f[3];
    chk_write("d", 3, 2, 2, 1'b1);
    tick();
    // m=0 start rejected
    start(4, 0, 2);
    chk("e.wen", 288'(bus.reg_write_en_out), 288'(0));
    chk("e.done", 288'(bus.collect_done_out), 288'(1));
    chk("e.err", 288'(bus.collect_error_out), 288'(1));
    chk("e.ready", 288'(bus.collector_ready_out), 288'(1));
    tick();
    chk("e.done_drop", 288'(bus.collect_done_out), 288'(0));
    // start during collection ignored; out-of-range index flags error
    start(6, 2, 2);
    res(0, 0, f[5], 1'b0);
    start(7, 2, 2);
    chk("f.ready_low", 288'(bus.collector_ready_out), 288'(0));
    res(0, 2, f[8], 1'b0);
    res(0, 1, f[6], 1'b0);
    res(1, 0, f[7], 1'b0);
    res(1, 1, f[8], 1'b0);
    em = '0;
    em[0] = f[5];
    em[1] = f[6];
    em[3] = f[7];
    em[4] = f[8];
    chk_write("f", 6, 2, 2, 1'b1);
    tick();
    // reset mid-collection abandons the operation
    start(0, 3, 3);
    for (int i = 0; i < 4; i++) res(i / 3, i % 3, f[8 - i], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("g.ready", 288'(bus.collector_ready_out), 288'(1));
    chk("g.wen", 288'(bus.reg_write_en_out), 288'(0));
    chk("g.done", 288'(bus.collect_done_out), 288'(0));
    chk("g.mat", bus.reg_write_matrix_out, 288'(0));
    start(1, 2, 2);
    res(0, 0, f[0], 1'b0);
    res(1, 1, f[3], 1'b0);
    res(0, 1, f[1], 1'b0);
    res(1, 0, f[2], 1'b0);
    em = '0;
    em[0] = f[0];
    em[1] = f[1];
    em[3] = f[2];
    em[4] = f[3];
    chk_write("h", 1, 2, 2, 1'b0);
    tick();
    chk("h.ready", 288'(bus.collector_ready_out), 288'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
